reg_mux: RTL and testbench

- Registered 2:1 data selector with valid/ready flow control on both sides.
- Each accepted input beat forwards data_in0 when sel=0 and data_in1 when sel=1.
- The chosen word goes to a registered output stage.
- Sits between two streaming producers/consumers in the datapath and provides full throughput with a registered in_ready (skid buffer).

---
 rtl/reg_mux_pkg.sv | 14 +
 rtl/reg_mux_skid.sv | 54 +++++
 rtl/reg_mux.sv | 87 ++++++++
 tb/tb_reg_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_mux_pkg.sv
// reg_mux shared constants.
// Default width and reset value of the output word.
package reg_mux_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic DATA_RST_BIT = 1'b0;

  localparam logic [DEF_WIDTH-1:0] DATA_RST =
    {DEF_WIDTH{DATA_RST_BIT}};

  localparam logic SEL_RST = 1'b0;

endpackage

// File: rtl/reg_mux_skid.sv
// reg_mux_skid: one-entry skid buffer, valid/ready both sides.
// s_ready is registered; it is high exactly when the entry is empty.
module reg_mux_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  import reg_mux_pkg::*;

  logic         full;
  logic         full_next;
  logic         acc;
  logic [W-1:0] hold;

  assign acc = s_valid & s_ready;

  // The held entry always goes out before a fresh beat.
  assign m_valid = full | acc;
  assign m_data  = full ? hold : s_data;

  // Entry fills on an accepted beat the consumer cannot take.
  always_comb begin
    full_next = full;
    if (full) begin
      full_next = ~m_ready;
    end else begin
      full_next = acc & ~m_ready;
    end
  end

  // Entry storage and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      hold    <= {W{DATA_RST_BIT}};
      s_ready <= 1'b1;
    end else begin
      full    <= full_next;
      s_ready <= ~full_next;
      if (!full && acc && !m_ready) begin
        hold <= s_data;
      end
    end
  end

endmodule

// File: rtl/reg_mux.sv
// reg_mux: registered 2:1 selector with skid-buffered valid/ready.
// Define REG_MUX_PARITY_EN to add the registered parity_out port.
module reg_mux
  import reg_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_out
`ifdef REG_MUX_PARITY_EN
  ,
  output logic             parity_out
`endif
);

`ifdef REG_MUX_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] word;
  logic [PW-1:0]    in_pl;
  logic [PW-1:0]    out_pl;
  logic             sk_valid;
  logic             load;

  assign word = sel ? data_in1 : data_in0;

`ifdef REG_MUX_PARITY_EN
  assign in_pl = {^word, sel, word};
`else
  assign in_pl = {sel, word};
`endif

  // Output stage takes a word when empty or draining.
  assign load = ~out_valid | out_ready;

  reg_mux_skid #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (in_valid),
    .s_ready (in_ready),
    .s_data  (in_pl),
    .m_valid (sk_valid),
    .m_ready (load),
    .m_data  (out_pl)
  );

  // Output register; word/sel only change on a real load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= {WIDTH{DATA_RST_BIT}};
      sel_out   <= SEL_RST;
    end else if (load) begin
      out_valid <= sk_valid;
      if (sk_valid) begin
        data_out <= out_pl[WIDTH-1:0];
        sel_out  <= out_pl[WIDTH];
      end
    end
  end

`ifdef REG_MUX_PARITY_EN
  // Parity travels with the word it was computed from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_out <= 1'b0;
    end else if (load && sk_valid) begin
      parity_out <= out_pl[WIDTH+1];
    end
  end
`endif

endmodule

// File: tb/tb_reg_mux.sv
// tb_reg_mux: random + directed bench for reg_mux.
// Reference is a 2-deep FIFO model of the whole block.
module tb_reg_mux;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in0;
  logic [W-1:0] data_in1;
  logic         sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         sel_out;
`ifdef REG_MUX_PARITY_EN
  logic         parity_out;
`endif

  reg_mux #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_out    (sel_out)
`ifdef REG_MUX_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: beats inside the block, oldest first; {sel, data}.
  logic [W:0] q[$];
  logic [W:0] last = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] shown();
    return (q.size() > 0) ? q[0] : last;
  endfunction

  task automatic compare_all();
    logic [W:0] s;
    s = shown();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("data_out", 32'(data_out), 32'(s[W-1:0]));
    check("sel_out", 32'(sel_out), 32'(s[W]));
`ifdef REG_MUX_PARITY_EN
    check("parity_out", 32'(parity_out), 32'(^s[W-1:0]));
`endif
  endtask

  // Drive one cycle (from a negedge), advance model, compare.
  task automatic step(input logic iv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s,
                      input logic ordy);
    logic acc;
    logic drn;
    in_valid  = iv;
    data_in0  = a;
    data_in1  = b;
    sel       = s;
    out_ready = ordy;
    @(posedge clk);
    acc = iv && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (drn) last = q.pop_front();
    if (acc) q.push_back({s, s ? b : a});
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in0 = '0;
    data_in1 = '0;
    sel = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Basic selection and back-to-back throughput.
    step(1, 8'd15, 8'd5, 0, 1);
    check("first_d0", 32'(data_out), 32'd15);
    step(1, 8'd15, 8'd5, 1, 1);
    check("second_d1", 32'(data_out), 32'd5);
    check("second_sel", 32'(sel_out), 32'd1);
    step(0, 8'd0, 8'd0, 0, 1);

    // Backpressure fills output then skid.
    step(1, 8'd15, 8'd5, 0, 0);
    step(1, 8'd15, 8'd5, 1, 0);
    check("bp_hold", 32'(data_out), 32'd15);
    check("bp_ready0", 32'(in_ready), 32'd0);
    step(1, 8'd15, 8'd5, 0, 0);
    step(1, 8'd15, 8'd5, 0, 1);
    check("bp_rel1", 32'(data_out), 32'd5);
    step(1, 8'd15, 8'd5, 0, 1);
    check("bp_rel2", 32'(data_out), 32'd15);
    step(0, 8'd0, 8'd0, 0, 1);

    // Idle inputs wiggling must not disturb outputs.
    for (int i = 0; i < 6; i++)
      step(0, W'($urandom), W'($urandom), 1'($urandom), 1);
    check("idle_data", 32'(data_out), 32'd15);

`ifdef REG_MUX_PARITY_EN
    step(1, 8'h0F, 8'h07, 0, 1);
    check("par_0f", 32'(parity_out), 32'd0);
    step(1, 8'h0F, 8'h07, 1, 1);
    check("par_07", 32'(parity_out), 32'd1);
    step(0, 8'h00, 8'h00, 0, 1);
`endif

    // Random traffic with mixed backpressure.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 99) < 70), W'($urandom),
           W'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 60));
    end

    // Async reset with output full and skid full.
    step(1, 8'hA5, 8'h3C, 0, 1);
    step(1, 8'hA5, 8'h3C, 1, 0);
    step(1, 8'h11, 8'h22, 1, 0);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_sel", 32'(sel_out), 32'd0);
    q.delete();
    last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h5A, 8'hC3, 1, 1);
    check("post_rst", 32'(data_out), 32'hC3);
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), W'($urandom), W'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
